// File: rtl/fifo_pkg.sv
// Shared constants for the lookahead FIFO and its non-lookahead wrapper.
// Holds the default word width and log2 depth used by both modules.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_LOG2_DEF = 4;

endpackage

// File: rtl/fifo_lookahead.sv
// Lookahead (first-word-fall-through) FIFO core: head word is always on dout.
// Ports: clk, rst (async active-low), wr/din push, pop, full, empty, dout.
module fifo_lookahead
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_CNT = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] ONE_PTR = DEPTH_LOG2'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  push;
    logic                  pop_ok;

    // Flags come from the registered count only.
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign push   = wr && !full;
    assign pop_ok = pop && !empty;
    assign dout   = mem[rd_ptr];

    // Storage is not reset; stale words are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            unique case ({push, pop_ok})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_la_to_nla_wrapper.sv
// Presents a lookahead FIFO as a non-lookahead FIFO with registered dout.
// Ports: clk, rst (async active-low), wr/din/full, rd/empty/dout, _dout/_empty/_rd debug.
module fifo_la_to_nla_wrapper
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  rd,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_WIDTH-1:0] _dout,
    output logic                  _empty,
    output logic                  _rd
);

    fifo_lookahead #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .din   (din),
        .pop   (_rd),
        .full  (full),
        .empty (_empty),
        .dout  (_dout)
    );

    assign empty = _empty;
    assign _rd   = rd && !_empty;

    // Capture the head word on the pop so it appears one cycle after rd.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
        end else if (_rd) begin
            dout <= _dout;
        end
    end

endmodule

// File: tb/tb_fifo_la_to_nla_wrapper.sv
// Self-checking bench for fifo_la_to_nla_wrapper (queue model + scoreboard).
// Drives on negedge, checks flags before the rising edge and dout after it.
module tb_fifo_la_to_nla_wrapper;

    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rd = 1'b0;
    logic          full;
    logic          empty;
    logic [DW-1:0] dout;
    logic [DW-1:0] la_dout;
    logic          la_empty;
    logic          la_rd;

    int n_pass = 0;
    int n_total = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_dout = '0;

    typedef struct {
        logic          wr;
        logic [DW-1:0] din;
        logic          rd;
        logic          exp_empty;
        logic          exp_rd;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t vt[5];

    always #5 clk = ~clk;

    fifo_la_to_nla_wrapper #(
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr),
        .din    (din),
        .full   (full),
        .rd     (rd),
        .empty  (empty),
        .dout   (dout),
        ._dout  (la_dout),
        ._empty (la_empty),
        ._rd    (la_rd)
    );

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock cycle against the queue model.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        logic e_empty;
        logic e_full;
        logic pop;
        @(negedge clk);
        wr = w;
        din = d;
        rd = r;
        #1;
        e_empty = (mq.size() == 0);
        e_full = (mq.size() == DEPTH);
        pop = r && !e_empty;
        check("empty", {31'd0, empty}, {31'd0, e_empty});
        check("_empty", {31'd0, la_empty}, {31'd0, e_empty});
        check("full", {31'd0, full}, {31'd0, e_full});
        check("_rd", {31'd0, la_rd}, {31'd0, pop});
        if (!e_empty) check("_dout", la_dout, mq[0]);
        if (pop) sb.push_back(mq.pop_front());
        if (w && !e_full) mq.push_back(d);
        @(posedge clk);
        #1;
        if (pop) exp_dout = sb.pop_front();
        check("dout", dout, exp_dout);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && mq.size() > 0; i++) step(1'b0, '0, 1'b1);
        check("drain_done", {31'd0, empty}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
        mq.delete();
        sb.delete();
        exp_dout = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vt[0] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00};
        vt[1] = '{1'b1, 32'h5A, 1'b1, 1'b1, 1'b0, 32'h00};
        vt[2] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h5A};
        vt[3] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h5A};
        vt[4] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h5A};

        // Reset state with rd asserted
        rst = 1'b0;
        rd = 1'b1;
        #12;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst__empty", {31'd0, la_empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst__rd", {31'd0, la_rd}, 32'd0);
        @(negedge clk);
        rd = 1'b0;
        rst = 1'b1;

        // Read held on empty, then a write arrives
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr = vt[i].wr;
            din = vt[i].din;
            rd = vt[i].rd;
            #1;
            check($sformatf("tbl%0d_empty", i), {31'd0, empty},
                  {31'd0, vt[i].exp_empty});
            check($sformatf("tbl%0d__rd", i), {31'd0, la_rd},
                  {31'd0, vt[i].exp_rd});
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_dout", i), dout, vt[i].exp_dout);
        end
        exp_dout = 32'h5A;

        // Eight words with random reads
        begin
            logic [DW-1:0] pat[8];
            pat = '{32'h5A, 32'hF6, 32'h09, 32'hC4,
                    32'h81, 32'hE2, 32'hA0, 32'h7A};
            for (int i = 0; i < 8; i++) begin
                step(1'b1, pat[i], 1'($urandom_range(0, 1)));
            end
            drain();
        end

        // Fill to full, drop 17th, read back 16
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + i, 1'b0);
        step(1'b1, 32'hDEAD, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            check("fill_order", dout, 32'h100 + i);
        end
        step(1'b0, '0, 1'b0);

        // Streaming read+write across pointer wrap
        step(1'b1, 32'h1000, 1'b0);
        for (int i = 1; i <= 40; i++) step(1'b1, 32'h1000 + i, 1'b1);
        drain();

        // Async reset mid-stream with 5 words stored
        for (int i = 0; i < 5; i++) step(1'b1, 32'h2000 + i, 1'b0);
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_empty", {31'd0, empty}, 32'd1);
        check("arst__empty", {31'd0, la_empty}, 32'd1);
        check("arst_full", {31'd0, full}, 32'd0);
        check("arst_dout", dout, 32'd0);
        check("arst__rd", {31'd0, la_rd}, 32'd0);
        mq.delete();
        sb.delete();
        exp_dout = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h3000, 1'b0);
        step(1'b0, '0, 1'b1);
        check("post_rst_word", dout, 32'h3000);
        step(1'b0, '0, 1'b1);

        do_reset();
        #1;
        check("final_empty", {31'd0, empty}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
